// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL start-up sequencer: state encoding,
// default timing constants, the retry counter width and a small helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STABLE,
        EN_CLK,
        RUN
    } pll_seq_state_t;

    localparam int DEF_PLL_RST_CYC      = 16;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_EN_GAP_CYC       = 8;
    localparam int DEF_LOCK_TIMEOUT_CYC = 65536;

    localparam int RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_seq_ctrl_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the clk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    output logic lock_s
);

    logic meta;

    // Shift the raw lock through two flops; reset clears both stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            meta   <= pll_lock;
            lock_s <= meta;
        end
    end

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL start-up sequencer: pulses PLL reset, waits for a stable lock, staggers
// the three clock enables, then releases the downstream reset.
// Optional feature: define PLL_SEQ_TIMEOUT_EN to retry the PLL reset when lock
// does not arrive within LOCK_TIMEOUT_CYC cycles (retry_cnt counts retries).
// LOCK_STABLE_CYC must be at least 2: the lock cycle seen in WAIT_LOCK counts
// as the first stable cycle.
module pll_seq_ctrl
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int EN_GAP_CYC       = DEF_EN_GAP_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               soft_rst,
    output logic               pll_rst,
    output logic [2:0]         enclk,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_MAX = max_int(max_int(PLL_RST_CYC, LOCK_STABLE_CYC),
                                     max_int(3 * EN_GAP_CYC, LOCK_TIMEOUT_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 2);
    localparam logic [CNT_W-1:0] GAP1_LAST   = CNT_W'(EN_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP2_LAST   = CNT_W'(2 * EN_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP3_LAST   = CNT_W'(3 * EN_GAP_CYC - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
`endif

    pll_seq_state_t   state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       enclk_nx;
    logic             lock_lost_nx;
    logic             pll_rst_nx, sys_rst_nx, ready_nx;
    logic             lock_s;
`ifdef PLL_SEQ_TIMEOUT_EN
    logic             retry_inc;
`endif

    pll_lock_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .lock_s   (lock_s)
    );

    // Next-state, counter and next-output decode; soft_rst overrides everything.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        enclk_nx     = enclk;
        lock_lost_nx = lock_lost;
`ifdef PLL_SEQ_TIMEOUT_EN
        retry_inc    = 1'b0;
`endif
        case (state)
            RST_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end
`ifdef PLL_SEQ_TIMEOUT_EN
                else if (cnt == TIMEOUT_LAST) begin
                    state_nx  = RST_PLL;
                    cnt_nx    = '0;
                    retry_inc = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
`endif
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = EN_CLK;
                    cnt_nx   = '0;
                    enclk_nx = 3'b001;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            EN_CLK: begin
                if (!lock_s) begin
                    state_nx = RST_PLL;
                    cnt_nx   = '0;
                    enclk_nx = 3'b000;
                end else if (cnt == GAP3_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == GAP1_LAST) enclk_nx = 3'b011;
                    if (cnt == GAP2_LAST) enclk_nx = 3'b111;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx     = RST_PLL;
                    cnt_nx       = '0;
                    enclk_nx     = 3'b000;
                    lock_lost_nx = 1'b1;
                end
            end
            default: begin
                state_nx = RST_PLL;
                cnt_nx   = '0;
                enclk_nx = 3'b000;
            end
        endcase
        if (soft_rst) begin
            state_nx = RST_PLL;
            cnt_nx   = '0;
            enclk_nx = 3'b000;
`ifdef PLL_SEQ_TIMEOUT_EN
            retry_inc = 1'b0;
`endif
        end
        pll_rst_nx = (state_nx == RST_PLL);
        sys_rst_nx = (state_nx != RUN);
        ready_nx   = (state_nx == RUN);
    end

    // State, counter and registered outputs; reset forces the PLL-reset state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RST_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            enclk     <= 3'b000;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            pll_rst   <= pll_rst_nx;
            enclk     <= enclk_nx;
            sys_rst   <= sys_rst_nx;
            ready     <= ready_nx;
            lock_lost <= lock_lost_nx;
        end
    end

`ifdef PLL_SEQ_TIMEOUT_EN
    // Saturating count of lock timeouts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if (retry_inc && retry_cnt != RETRY_MAX) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    assign retry_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed self-checking bench for pll_seq_ctrl with shortened timing.
module tb_pll_seq_ctrl;

    localparam int PLL_RST_CYC      = 4;
    localparam int LOCK_STABLE_CYC  = 8;
    localparam int EN_GAP_CYC       = 2;
    localparam int LOCK_TIMEOUT_CYC = 32;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       pll_lock = 1'b0;
    logic       soft_rst = 1'b0;
    logic       pll_rst;
    logic [2:0] enclk;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic [6:0] obs;

    int checks = 0;
    int errors = 0;

    pll_seq_ctrl #(
        .PLL_RST_CYC      (PLL_RST_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .EN_GAP_CYC       (EN_GAP_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .soft_rst  (soft_rst),
        .pll_rst   (pll_rst),
        .enclk     (enclk),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    // Observed outputs packed as {pll_rst, enclk[2:0], sys_rst, ready, lock_lost}.
    assign obs = {pll_rst, enclk, sys_rst, ready, lock_lost};

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges and release it mid-cycle; caller is then in cycle 0.
    task automatic do_reset();
        reset    = 1'b1;
        pll_lock = 1'b0;
        soft_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        pll_lock = 1'b0;
        soft_rst = 1'b0;
        step(3);
        checks++;
        if (obs !== 7'b1000100) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 7'b1000100);
        end
        checks++;
        if (retry_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_retry: got %0d expected 0", retry_cnt);
        end
    endtask

    task automatic test_power_up();
        do_reset();
        checks++;
        if (obs !== 7'b1000100) begin
            errors++;
            $display("[TB] FAIL pwr_c0: got %b expected %b", obs, 7'b1000100);
        end
        step(3);
        checks++;
        if (obs !== 7'b1000100) begin
            errors++;
            $display("[TB] FAIL pwr_c3: got %b expected %b", obs, 7'b1000100);
        end
        step(1);
        checks++;
        if (obs !== 7'b0000100) begin
            errors++;
            $display("[TB] FAIL pwr_c4: got %b expected %b", obs, 7'b0000100);
        end
        step(6);
        pll_lock = 1'b1;
        step(9);
        checks++;
        if (obs !== 7'b0000100) begin
            errors++;
            $display("[TB] FAIL pwr_c19: got %b expected %b", obs, 7'b0000100);
        end
        step(1);
        checks++;
        if (obs !== 7'b0001100) begin
            errors++;
            $display("[TB] FAIL pwr_c20_en0: got %b expected %b", obs, 7'b0001100);
        end
        step(2);
        checks++;
        if (obs !== 7'b0011100) begin
            errors++;
            $display("[TB] FAIL pwr_c22_en1: got %b expected %b", obs, 7'b0011100);
        end
        step(2);
        checks++;
        if (obs !== 7'b0111100) begin
            errors++;
            $display("[TB] FAIL pwr_c24_en2: got %b expected %b", obs, 7'b0111100);
        end
        step(1);
        checks++;
        if (obs !== 7'b0111100) begin
            errors++;
            $display("[TB] FAIL pwr_c25: got %b expected %b", obs, 7'b0111100);
        end
        step(1);
        checks++;
        if (obs !== 7'b0111010) begin
            errors++;
            $display("[TB] FAIL pwr_c26_run: got %b expected %b", obs, 7'b0111010);
        end
    endtask

    task automatic test_lock_loss_run();
        pll_lock = 1'b0;
        step(2);
        checks++;
        if (obs !== 7'b0111010) begin
            errors++;
            $display("[TB] FAIL loss_c2: got %b expected %b", obs, 7'b0111010);
        end
        step(1);
        checks++;
        if (obs !== 7'b1000101) begin
            errors++;
            $display("[TB] FAIL loss_c3: got %b expected %b", obs, 7'b1000101);
        end
        step(3);
        checks++;
        if (obs !== 7'b1000101) begin
            errors++;
            $display("[TB] FAIL loss_c6: got %b expected %b", obs, 7'b1000101);
        end
        step(1);
        checks++;
        if (obs !== 7'b0000101) begin
            errors++;
            $display("[TB] FAIL loss_c7: got %b expected %b", obs, 7'b0000101);
        end
    endtask

    task automatic test_glitch_and_en_drop();
        do_reset();
        step(4);
        pll_lock = 1'b1;
        step(6);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(2);
        checks++;
        if (obs !== 7'b0000100) begin
            errors++;
            $display("[TB] FAIL glitch_c13: got %b expected %b", obs, 7'b0000100);
        end
        step(1);
        checks++;
        if (obs !== 7'b0000100) begin
            errors++;
            $display("[TB] FAIL glitch_c14: got %b expected %b", obs, 7'b0000100);
        end
        step(6);
        checks++;
        if (obs !== 7'b0000100) begin
            errors++;
            $display("[TB] FAIL glitch_c20: got %b expected %b", obs, 7'b0000100);
        end
        step(1);
        checks++;
        if (obs !== 7'b0001100) begin
            errors++;
            $display("[TB] FAIL glitch_c21_en0: got %b expected %b", obs, 7'b0001100);
        end
        pll_lock = 1'b0;
        step(2);
        checks++;
        if (obs !== 7'b0011100) begin
            errors++;
            $display("[TB] FAIL endrop_c23: got %b expected %b", obs, 7'b0011100);
        end
        step(1);
        checks++;
        if (obs !== 7'b1000100) begin
            errors++;
            $display("[TB] FAIL endrop_c24: got %b expected %b", obs, 7'b1000100);
        end
    endtask

    task automatic test_soft_rst();
        do_reset();
        pll_lock = 1'b1;
        step(18);
        checks++;
        if (obs !== 7'b0111010) begin
            errors++;
            $display("[TB] FAIL soft_run: got %b expected %b", obs, 7'b0111010);
        end
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        checks++;
        if (obs !== 7'b1000100) begin
            errors++;
            $display("[TB] FAIL soft_c19: got %b expected %b", obs, 7'b1000100);
        end
        step(3);
        checks++;
        if (obs !== 7'b1000100) begin
            errors++;
            $display("[TB] FAIL soft_c22: got %b expected %b", obs, 7'b1000100);
        end
        step(1);
        checks++;
        if (obs !== 7'b0000100) begin
            errors++;
            $display("[TB] FAIL soft_c23: got %b expected %b", obs, 7'b0000100);
        end
        step(10);
        checks++;
        if (obs !== 7'b0011100) begin
            errors++;
            $display("[TB] FAIL soft_c33_enclk: got %b expected %b", obs, 7'b0011100);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== 7'b1000100) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b expected %b", obs, 7'b1000100);
        end
        checks++;
        if (retry_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_retry: got %0d expected 0", retry_cnt);
        end
    endtask

    task automatic test_soft_lock_combo();
        do_reset();
        pll_lock = 1'b1;
        step(18);
        pll_lock = 1'b0;
        step(2);
        checks++;
        if (obs !== 7'b0111010) begin
            errors++;
            $display("[TB] FAIL combo_c20: got %b expected %b", obs, 7'b0111010);
        end
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        checks++;
        if (obs !== 7'b1000101) begin
            errors++;
            $display("[TB] FAIL combo_c21: got %b expected %b", obs, 7'b1000101);
        end
    endtask

`ifdef PLL_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        step(35);
        checks++;
        if ({pll_rst, retry_cnt} !== {1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL tmo_c35: got pll_rst=%b retry=%0d expected 0/0", pll_rst, retry_cnt);
        end
        step(1);
        checks++;
        if ({pll_rst, retry_cnt} !== {1'b1, 4'd1}) begin
            errors++;
            $display("[TB] FAIL tmo_c36: got pll_rst=%b retry=%0d expected 1/1", pll_rst, retry_cnt);
        end
        step(36);
        checks++;
        if ({pll_rst, retry_cnt} !== {1'b1, 4'd2}) begin
            errors++;
            $display("[TB] FAIL tmo_c72: got pll_rst=%b retry=%0d expected 1/2", pll_rst, retry_cnt);
        end
        step(468);
        checks++;
        if ({pll_rst, retry_cnt} !== {1'b1, 4'd15}) begin
            errors++;
            $display("[TB] FAIL tmo_c540: got pll_rst=%b retry=%0d expected 1/15", pll_rst, retry_cnt);
        end
        step(35);
        checks++;
        if ({pll_rst, retry_cnt} !== {1'b0, 4'd15}) begin
            errors++;
            $display("[TB] FAIL tmo_c575: got pll_rst=%b retry=%0d expected 0/15", pll_rst, retry_cnt);
        end
        step(1);
        checks++;
        if ({pll_rst, retry_cnt} !== {1'b1, 4'd15}) begin
            errors++;
            $display("[TB] FAIL tmo_c576_sat: got pll_rst=%b retry=%0d expected 1/15", pll_rst, retry_cnt);
        end
    endtask
`else
    task automatic test_timeout();
        do_reset();
        step(200);
        checks++;
        if ({pll_rst, retry_cnt} !== {1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL no_tmo_c200: got pll_rst=%b retry=%0d expected 0/0", pll_rst, retry_cnt);
        end
    endtask
`endif

    initial begin
        $display("[TB] starting pll_seq_ctrl bench");
        test_reset();
        test_power_up();
        test_lock_loss_run();
        test_glitch_and_en_drop();
        test_soft_rst();
        test_soft_lock_combo();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_seq_ctrl.md
PLL_SEQ_CTRL -- requirements
Module: pll_seq_ctrl

Interface
REQ-001 SHALL have parameter PLL_RST_CYC, default 16: number of cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 1024: number of consecutive synchronized-lock cycles required before clock enables start.
REQ-003 SHALL have parameter EN_GAP_CYC, default 8: number of cycles between successive enclk assertions, and from the last assertion to RUN.
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYC, default 65536: maximum number of WAIT_LOCK cycles before a PLL reset is retried.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, free-running PLL reference.
REQ-006 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clk.
REQ-008 SHALL have port soft_rst, input, 1 bit: synchronous request to restart the sequence.
REQ-009 SHALL have port pll_rst, output, 1 bit: drives PLL RESET.
REQ-010 SHALL have port enclk, output, 3 bits: drive ENCLK0..2.
REQ-011 SHALL have port sys_rst, output, 1 bit: active-high downstream reset.
REQ-012 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-013 SHALL have port lock_lost, output, 1 bit: sticky flag, set on lock loss in RUN.
REQ-014 SHALL have port retry_cnt, output, 4 bits: saturating count of lock timeouts.

Function
REQ-015 pll_lock SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-016 States SHALL be RST_PLL, WAIT_LOCK, STABLE, EN_CLK, RUN; all outputs registered.
REQ-017 RST_PLL: pll_rst=1, enclk=0, sys_rst=1; after PLL_RST_CYC cycles the block SHALL go to WAIT_LOCK with pll_rst=0.
REQ-018 WAIT_LOCK: lock_s=1 SHALL move the block to STABLE with the counter cleared.
REQ-019 STABLE: the counter SHALL count consecutive lock_s=1 cycles; lock_s=0 SHALL return to WAIT_LOCK without a PLL reset; reaching LOCK_STABLE_CYC SHALL move to EN_CLK.
REQ-020 EN_CLK: enclk[0] SHALL rise on entry, enclk[1] EN_GAP_CYC cycles later, then enclk[2] EN_GAP_CYC cycles after that; after a further EN_GAP_CYC cycles the block SHALL enter RUN.
REQ-021 EN_CLK: a lock_s drop SHALL clear enclk and go to RST_PLL; lock_lost is not set.
REQ-022 RUN: sys_rst=0, ready=1, enclk=3'b111.
REQ-023 RUN: lock_s=0 SHALL, on the next edge, give enclk=0, sys_rst=1, ready=0, lock_lost=1, state RST_PLL.
REQ-024 soft_rst=1 in any state SHALL force RST_PLL on the next edge with outputs as REQ-017; lock_lost is unaffected.
REQ-025 If soft_rst and a lock drop occur in the same RUN cycle, the result SHALL be RST_PLL with lock_lost=1.
REQ-026 Counters SHALL be sized $clog2(max parameter)+1; retry_cnt SHALL saturate at 15.

Reset
REQ-027 reset=1 SHALL immediately force state RST_PLL, pll_rst=1, enclk=0, sys_rst=1, ready=0, lock_lost=0, retry_cnt=0, synchronizer=0, counters=0.
REQ-028 On reset release, a full RST_PLL pulse of PLL_RST_CYC cycles SHALL occur.
REQ-029 reset asserted mid-sequence SHALL abort the sequence; no enclk glitch is allowed.

Configuration
REQ-030 Macro PLL_SEQ_TIMEOUT_EN SHALL gate the lock timeout feature.
REQ-031 When PLL_SEQ_TIMEOUT_EN is defined: after LOCK_TIMEOUT_CYC cycles in WAIT_LOCK, the block SHALL go to RST_PLL and increment retry_cnt.
REQ-032 When PLL_SEQ_TIMEOUT_EN is undefined: WAIT_LOCK SHALL wait indefinitely, retry_cnt SHALL be tied to 0, and the timeout counter SHALL be absent.

Structure
REQ-033 Shared package pll_seq_pkg SHALL hold the state enum, default parameter constants, and the retry_cnt width.
REQ-034 Sub-module pll_lock_sync SHALL hold the 2-flop synchronizer, with asynchronous active-high reset.

Verification (bench parameters: PLL_RST_CYC=4, LOCK_STABLE_CYC=8, EN_GAP_CYC=2, LOCK_TIMEOUT_CYC=32)
REQ-035 Release reset, raise pll_lock at cycle 10 -> pll_rst low from cycle 4; enclk[0] rises 8 cycles after lock_s rises; enclk[1] and enclk[2] follow at 2-cycle gaps; ready=1 and sys_rst=0 two cycles after enclk[2].
REQ-036 Lock glitch low for 1 cycle (post-sync) at STABLE count 5 -> return to WAIT_LOCK, counter restarts, pll_rst stays 0, enclk stays 0.
REQ-037 In RUN, drop pll_lock -> 3 cycles later (sync plus register) enclk=0, sys_rst=1, ready=0, lock_lost=1, pll_rst=1 for 4 cycles.
REQ-038 With timeout enabled, pll_lock held 0 -> pll_rst pulses every 4+32 cycles; retry_cnt counts 1, 2, … and saturates at 15.
REQ-039 soft_rst pulse in RUN, then reset asserted mid-EN_CLK -> RST_PLL with lock_lost=0; the reset clears all outputs to REQ-027 values asynchronously.
